// File: rtl/lsp_prev_compose_pkg.sv
// Shared constants and state encoding for the LSP previous-frame extract/compose blocks.
package lsp_prev_compose_pkg;
  localparam int M     = 10;  // LSP order
  localparam int MA_NP = 4;   // MA predictor order
  localparam int J_W   = 4;   // element index field in scratch/constant addresses
  localparam int K_W   = 2;   // predictor index field

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ELE = 3'd1,
    MULT   = 3'd2,
    MAC    = 3'd3,
    WRITE  = 3'd4
  } state_t;
endpackage

// File: rtl/lsp_prev_compose.sv
// Rebuilds lsp[j] = extract_h(L_mult(lsp_ele[j], fg_sum[j]) + sum_k L_mac(freq_prev[k][j], fg[k][j])).
module lsp_prev_compose
  import lsp_prev_compose_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  input  logic [11:0] lspele,
  input  logic [11:0] freq_prev,
  input  logic [11:0] lsp,
  input  logic [11:0] fgAddr,
  input  logic [11:0] fg_sumAddr,
  output logic [11:0] readAddr,
  input  logic [31:0] readIn,
  output logic [11:0] writeAddr,
  output logic [31:0] writeOut,
  output logic        writeEn,
  output logic [11:0] constantMemAddr,
  input  logic [31:0] constantMemIn,
  output logic [15:0] L_mult_a,
  output logic [15:0] L_mult_b,
  input  logic [31:0] L_mult_in,
  output logic [15:0] L_mac_a,
  output logic [15:0] L_mac_b,
  output logic [31:0] L_mac_c,
  input  logic [31:0] L_mac_in
);

  state_t           state, state_nx;
  logic [J_W-1:0]   j, j_nx;
  logic [K_W-1:0]   k, k_nx, k_inc;
  logic [31:0]      L_acc, L_acc_nx;

  // Base low bits are replaced by the j/k fields, and only the low data halves are used.
  logic unused_bits;
  assign unused_bits = ^{readIn[31:16], constantMemIn[31:16], lspele[3:0], freq_prev[5:0],
                         lsp[3:0], fgAddr[5:0], fg_sumAddr[3:0]};

  assign k_inc = k + 2'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      j     <= '0;
      k     <= '0;
      L_acc <= '0;
    end else begin
      state <= state_nx;
      j     <= j_nx;
      k     <= k_nx;
      L_acc <= L_acc_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    j_nx            = j;
    k_nx            = k;
    L_acc_nx        = L_acc;
    done            = 1'b0;
    readAddr        = '0;
    writeAddr       = '0;
    writeOut        = '0;
    writeEn         = 1'b0;
    constantMemAddr = '0;
    L_mult_a        = '0;
    L_mult_b        = '0;
    L_mac_a         = '0;
    L_mac_b         = '0;
    L_mac_c         = '0;
    case (state)
      IDLE: begin
        j_nx = '0;
        if (start) state_nx = RD_ELE;
      end
      RD_ELE: begin
        if (j == J_W'(M)) begin
          done     = 1'b1;
          j_nx     = '0;
          state_nx = IDLE;
        end else begin
          readAddr        = {lspele[11:4], j};
          constantMemAddr = {fg_sumAddr[11:4], j};
          state_nx        = MULT;
        end
      end
      MULT: begin
        L_mult_a        = readIn[15:0];
        L_mult_b        = constantMemIn[15:0];
        L_acc_nx        = L_mult_in;
        k_nx            = '0;
        readAddr        = {freq_prev[11:6], 2'd0, j};
        constantMemAddr = {fgAddr[11:6], 2'd0, j};
        state_nx        = MAC;
      end
      MAC: begin
        L_mac_a  = readIn[15:0];
        L_mac_b  = constantMemIn[15:0];
        L_mac_c  = L_acc;
        L_acc_nx = L_mac_in;
        if (k == K_W'(MA_NP - 1)) begin
          state_nx = WRITE;
        end else begin
          // Prefetch the next history/table pair so data lands with the next MAC cycle.
          k_nx            = k_inc;
          readAddr        = {freq_prev[11:6], k_inc, j};
          constantMemAddr = {fgAddr[11:6], k_inc, j};
        end
      end
      WRITE: begin
        writeAddr = {lsp[11:4], j};
        writeOut  = {16'h0000, L_acc[31:16]};
        writeEn   = 1'b1;
        j_nx      = j + 4'd1;
        state_nx  = RD_ELE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
